// File: rtl/image_sequencer.sv
// Screensaver show controller: owns the shared frame counter and fades
// between pattern generators on a dwell timer or on a skip request.
module image_sequencer #(
    parameter int NUM_IMAGES   = 2,
    parameter int DWELL_FRAMES = 600,
    parameter int STEP_FRAMES  = 4,
    parameter int SEL_W        = $clog2(NUM_IMAGES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    next_btn,
    input  logic                    pause,
    input  logic [4*NUM_IMAGES-1:0] img_r,
    input  logic [4*NUM_IMAGES-1:0] img_g,
    input  logic [4*NUM_IMAGES-1:0] img_b,
    output logic [31:0]             frame,
    output logic [SEL_W-1:0]        select,
    output logic [3:0]              r,
    output logic [3:0]              g,
    output logic [3:0]              b,
    output logic                    busy
);

    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    typedef enum logic [1:0] {
        SHOW,
        FADE_OUT,
        BLANK,
        FADE_IN
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic [31:0]      frame_q, frame_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [SW-1:0]    step_q, step_d;
    logic [2:0]       shift_q, shift_d;
    logic             skip_pending_q, skip_pending_d;
    logic             busy_q, busy_d;
    logic [3:0]       r_q, r_d, g_q, g_d, b_q, b_d;

    logic             skip;
    logic             step_last;
    logic [3:0]       src_r, src_g, src_b;

    assign src_r = img_r[{select_q, 2'b00} +: 4];
    assign src_g = img_g[{select_q, 2'b00} +: 4];
    assign src_b = img_b[{select_q, 2'b00} +: 4];

    always_comb begin
        state_d        = state_q;
        select_d       = select_q;
        frame_d        = frame_q;
        dwell_d        = dwell_q;
        step_d         = step_q;
        shift_d        = shift_q;
        skip_pending_d = skip_pending_q;
        skip           = next_btn | skip_pending_q;
        step_last      = (step_q == SW'(STEP_FRAMES - 1));

        if (frame_start && !pause) begin
            frame_d = frame_q + 32'd1;
        end

        unique case (state_q)
            SHOW: begin
                if (next_btn) begin
                    skip_pending_d = 1'b1;
                end
                if (frame_start) begin
                    // Paused: dwell holds but a skip still fires.
                    if (skip || (!pause && dwell_q == DW'(DWELL_FRAMES - 1))) begin
                        state_d        = FADE_OUT;
                        shift_d        = 3'd0;
                        step_d         = '0;
                        dwell_d        = '0;
                        skip_pending_d = 1'b0;
                    end else if (!pause) begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    if (step_last) begin
                        step_d  = '0;
                        shift_d = shift_q + 3'd1;
                        if (shift_q == 3'd3) begin
                            state_d  = BLANK;
                            select_d = (select_q == SEL_W'(NUM_IMAGES - 1)) ?
                                       '0 : select_q + SEL_W'(1);
                        end
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            BLANK: begin
                if (frame_start) begin
                    state_d = FADE_IN;
                    step_d  = '0;
                end
            end
            FADE_IN: begin
                if (frame_start) begin
                    if (step_last) begin
                        step_d  = '0;
                        shift_d = shift_q - 3'd1;
                        if (shift_q == 3'd1) begin
                            state_d = SHOW;
                            dwell_d = '0;
                        end
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            default: state_d = SHOW;
        endcase

        busy_d = (state_d != SHOW);
        r_d    = src_r >> shift_q;
        g_d    = src_g >> shift_q;
        b_d    = src_b >> shift_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= SHOW;
            select_q       <= '0;
            frame_q        <= '0;
            dwell_q        <= '0;
            step_q         <= '0;
            shift_q        <= 3'd0;
            skip_pending_q <= 1'b0;
            busy_q         <= 1'b0;
            r_q            <= 4'd0;
            g_q            <= 4'd0;
            b_q            <= 4'd0;
        end else begin
            state_q        <= state_d;
            select_q       <= select_d;
            frame_q        <= frame_d;
            dwell_q        <= dwell_d;
            step_q         <= step_d;
            shift_q        <= shift_d;
            skip_pending_q <= skip_pending_d;
            busy_q         <= busy_d;
            r_q            <= r_d;
            g_q            <= g_d;
            b_q            <= b_d;
        end
    end

    assign frame  = frame_q;
    assign select = select_q;
    assign busy   = busy_q;
    assign r      = r_q;
    assign g      = g_q;
    assign b      = b_q;

endmodule
